alu_result_serializer: RTL

- Downstream consumer of the ALU FIFO `top` block. It accepts each 9-bit ALU result over a valid/ready handshake and buffers one result in a holding register.
- It transmits each result as an asynchronous serial frame (start, 9 data bits LSB-first, optional parity, stop) on a single `tx` line.
- It also counts completed frames for debug and bring-up.

---
 rtl/alu_result_serializer_pkg.sv | 26 ++
 rtl/alu_result_serializer_if.sv | 22 ++
 rtl/alu_result_serializer_bit_tick_gen.sv | 40 ++++
 rtl/alu_result_serializer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_result_serializer_pkg.sv
// ---------------------------------------------------------------------------
// alu_fifo_pkg
// Shared constants and types for the ALU FIFO and its downstream serializer.
//   RESULT_W    : width of one ALU result (9 bits)
//   DATA_W      : FIFO entry width shared with the ALU FIFO (10 bits)
//   ser_state_t : serializer frame states
//   even_parity : XOR reduction of a result word
// ---------------------------------------------------------------------------
package alu_fifo_pkg;

  localparam int RESULT_W = 9;
  localparam int DATA_W   = 10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } ser_state_t;

  function automatic logic even_parity(input logic [RESULT_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/alu_result_serializer_if.sv
// ---------------------------------------------------------------------------
// alu_result_serializer_if
// Valid/ready result channel between the ALU FIFO (master) and the
// serializer (slave).
//   res_data  : ALU result word
//   res_valid : res_data is valid (master -> slave)
//   res_ready : slave can take a word (slave -> master)
// ---------------------------------------------------------------------------
interface alu_result_serializer_if
  import alu_fifo_pkg::*;
#(
  parameter int W = RESULT_W
);

  logic [W-1:0] res_data;
  logic         res_valid;
  logic         res_ready;

  modport master (output res_data, output res_valid, input res_ready);
  modport slave  (input res_data, input res_valid, output res_ready);

endinterface

// File: rtl/alu_result_serializer_bit_tick_gen.sv
// ---------------------------------------------------------------------------
// bit_tick_gen
// Bit-time counter for the serializer. Down-counts CLKS_PER_BIT cycles while
// run is high and pulses tick on the last cycle of each bit, then reloads.
// Held at reload while run is low so the first bit after leaving idle is full
// length.
//   clk   : clock
//   reset : asynchronous active-high reset
//   run   : frame in progress
//   tick  : one-cycle pulse on the last cycle of each bit time
// ---------------------------------------------------------------------------
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int            CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Reset to zero is safe: run cannot rise within one cycle of reset release,
  // so the counter is reloaded before the first bit starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!run || r_cnt == '0) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tick = run && (r_cnt == '0);

endmodule

// File: rtl/alu_result_serializer.sv
// ---------------------------------------------------------------------------
// alu_result_serializer
// Takes 9-bit ALU results over a valid/ready channel into a one-entry holding
// register and sends each one as an asynchronous serial frame on tx:
// start (0), data LSB first, optional even parity, stop (1). Counts completed
// frames.
//
// Build option: define ALU_SER_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit.
//
// Ports
//   clk         : clock, all state on posedge
//   reset       : asynchronous active-high reset; aborts any frame
//   res_if      : slave side of the result channel (res_data/valid/ready)
//   tx          : serial line, idles high
//   busy        : a frame is in progress
//   frame_count : completed frames, wraps
// ---------------------------------------------------------------------------
module alu_result_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int RESULT_W     = 9,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_result_serializer_if.slave res_if,
  output logic                   tx,
  output logic                   busy,
  output logic [CNT_W-1:0]       frame_count
);

  import alu_fifo_pkg::*;

  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("alu_result_serializer: CLKS_PER_BIT must be >= 1");
  end

  localparam int             BCW      = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(RESULT_W - 1);

  ser_state_t          r_state;
  ser_state_t          w_state_next;
  logic [RESULT_W-1:0] r_hold;
  logic                r_hold_full;
  logic [RESULT_W-1:0] r_shift;
  logic [BCW-1:0]      r_bit_cnt;
  logic [CNT_W-1:0]    r_frame_count;
  logic                w_accept;
  logic                w_load;
  logic                w_shift;
  logic                w_frame_done;
  logic                w_run;
  logic                w_tick;

  // Ready is gated by reset so nothing is offered while the block is held.
  assign res_if.res_ready = !r_hold_full && !reset;
  assign w_accept         = res_if.res_valid && res_if.res_ready;
  assign w_run            = (r_state != IDLE);

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_tick_gen (
    .clk  (clk),
    .reset(reset),
    .run  (w_run),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_load       = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        if (w_tick) w_state_next = DATA;
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == LAST_BIT) begin
`ifdef ALU_SER_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_tick) w_state_next = STOP;
      end
      STOP: begin
        if (w_tick) begin
          w_frame_done = 1'b1;
          // A waiting result starts immediately, no idle bit between frames.
          if (r_hold_full) begin
            w_load       = 1'b1;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Accept and load never coincide: accept needs the register empty, load
  // needs it full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= res_if.res_data;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_shift   <= r_hold;
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_shift   <= r_shift >> 1;
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

`ifdef ALU_SER_PARITY_EN
  logic r_parity;

  // Parity is taken from the whole word at load, before shifting destroys it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= even_parity(r_hold);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_count <= '0;
    end else if (w_frame_done) begin
      r_frame_count <= r_frame_count + 1'b1;
    end
  end

  // tx decodes straight from the state register, so an asynchronous reset
  // forces the line high without waiting for a clock edge.
  always_comb begin
    tx = 1'b1;
    case (r_state)
      START: tx = 1'b0;
      DATA:  tx = r_shift[0];
`ifdef ALU_SER_PARITY_EN
      PARITY: tx = r_parity;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign busy        = (r_state != IDLE);
  assign frame_count = r_frame_count;

endmodule
